muldiv_iter_core: RTL and testbench
===================================

Name: muldiv_iter_core

Overview:
Front end and iterative engine of the RV32M unit. It accepts an M-extension request, decodes funct3, and converts signed operands to magnitudes while capturing their sign bits. It then runs an unsigned radix-2 shift-add multiply or restoring divide, and presents the raw magnitude results (P, Q, R), sign flags and op codes to the combinational sign-fixup output stage, which produces the final rd value.

Parameters:
STEPS_PER_CYCLE, 1, iterations per clock; legal values 1, 2, 4; iteration latency is 32/STEPS_PER_CYCLE.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  core can accept; high only in IDLE
funct3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  32  operand A / dividend
rs2  in  32  operand B / divisor
kill  in  1  synchronous abort of the in-flight op
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
is_div  out  1  registered funct3[2]
op_mul  out  2  funct3[1:0] when MUL class, else 0
op_div  out  2  funct3[1:0] when DIV class, else 0
p  out  64  unsigned product of magnitudes
q  out  32  unsigned quotient of magnitudes
r  out  32  unsigned remainder of magnitudes
sign_a  out  1  sign flag of A / dividend
sign_b  out  1  sign flag of B / divisor
divisor_2c  out  32  two's complement of rs2 (~rs2+1), registered at accept

Behaviour:
- States: IDLE, CALC, DONE. Reset or kill forces IDLE. All outputs and datapath registers reset to 0.
- IDLE: in_ready=1. A handshake (in_valid and in_ready) latches funct3, divisor_2c, signs and magnitudes, clears the iteration counter, and goes to CALC.
- Sign rules:
  - MUL/MULH: sign_a=rs1[31], sign_b=rs2[31].
  - MULHSU: sign_a=rs1[31], sign_b=0.
  - MULHU/DIVU/REMU: both 0.
  - DIV/REM: sign_a=rs1[31], sign_b=rs2[31].
  - Magnitude = two's complement when the flag is set, else raw. 0x80000000 magnitude = 0x80000000, treated as unsigned.
- CALC, multiply: LSB-first shift-add into a 64-bit accumulator, STEPS_PER_CYCLE bits per clock.
- CALC, divide: restoring, MSB-first; 33-bit partial remainder, quotient shifted in.
- CALC lasts exactly 32/STEPS_PER_CYCLE cycles, then DONE.
- Divide by zero (rs2==0, any DIV class):
  - Iteration still runs unless the optional feature is compiled in.
  - Final q=0xFFFFFFFF, r=raw rs1 (not magnitude), sign_a=sign_b=0 forced, so downstream passes the values unchanged.
- Overflow (DIV/REM 0x80000000 / 0xFFFFFFFF): no special case. Magnitudes give q=0x80000000, r=0, signs 1,1.
- DONE: out_valid=1. All result outputs are held stable until out_ready. On out_valid and out_ready, go to IDLE; in_ready rises the next cycle. No same-cycle re-accept.
- kill: has priority over every transition. From CALC or DONE it goes to IDLE next cycle with out_valid=0 and the result registers unchanged. kill in IDLE is ignored.
- Async reset mid-op: immediate IDLE with zeroed outputs. No result is produced for the interrupted op.
- Latency, STEPS_PER_CYCLE=1: accept at cycle 0, out_valid first high at cycle 33.

Optional Feature:
MULDIV_EARLY_OUT_EN.
- Defined: these cases skip CALC and go straight to DONE, with out_valid at cycle 1:
  - Divide by zero, with the forced results above.
  - Multiply with either magnitude zero: p=0.
  - Divide with |rs2|==1: q=|rs1|, r=0.
- Undefined: every op takes the full CALC latency, with identical results.

Test Plan:
1. MULH rs1=0xFFFFFFFE, rs2=3, STEPS=1 -> out_valid at cycle 33, p=0x0000000000000006, sign_a=1, sign_b=0, op_mul=01.
2. DIV rs1=0xFFFFFFF9, rs2=2 -> q=3, r=1, sign_a=1, sign_b=0, op_div=00, divisor_2c=0xFFFFFFFE.
3. REM rs1=0x80000005, rs2=0 -> q=0xFFFFFFFF, r=0x80000005, sign_a=sign_b=0. Cycle 33 without MULDIV_EARLY_OUT_EN, cycle 1 with it.
4. DIV rs1=0x80000000, rs2=0xFFFFFFFF -> q=0x80000000, r=0, sign_a=1, sign_b=1.
5. MULHU 0xFFFFFFFF x 0xFFFFFFFF with out_ready low for 5 cycles in DONE -> p=0xFFFFFFFE00000001 held, in_ready=0 throughout; in_ready=1 one cycle after the handshake.
6. kill at CALC cycle 10 -> out_valid never asserts, in_ready=1 next cycle. Separately, rst_n low mid-CALC -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: RV32M front end plus iterative radix-2 multiply/divide engine.
// Decodes funct3, takes operand magnitudes and sign flags, runs a shift-add
// multiply or a restoring divide, and holds raw magnitude results for the
// downstream sign-fixup stage.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        request handshake (in_ready high only in IDLE)
//   funct3, rs1, rs2         RV32M op and operands
//   kill                     synchronous abort of the in-flight op
//   out_valid/out_ready      result handshake
//   is_div, op_mul, op_div   registered op class and sub-op
//   p, q, r                  product, quotient, remainder of the magnitudes
//   sign_a, sign_b           operand sign flags for the fixup stage
//   divisor_2c               ~rs2+1 captured at accept
// Build option: define MULDIV_EARLY_OUT_EN to finish divide-by-zero,
// zero-operand multiply and unit-divisor divide without iterating.
module muldiv_iter_core #(
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic        kill,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        is_div,
   output logic [1:0]  op_mul,
   output logic [1:0]  op_div,
   output logic [63:0] p,
   output logic [31:0] q,
   output logic [31:0] r,
   output logic        sign_a,
   output logic        sign_b,
   output logic [31:0] divisor_2c
);

   localparam int NCYC = 32 / STEPS_PER_CYCLE;
   localparam logic [5:0] LAST = 6'(NCYC - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state;

   logic [5:0]  cnt;
   logic [63:0] acc;
   logic [63:0] mcand;
   logic [31:0] mplier;
   logic [31:0] rem;
   logic [31:0] quo;
   logic [31:0] dvsr;
   logic [31:0] raw_a;
   logic        div0;

   logic        sa_in;
   logic        sb_in;
   logic        dz_in;
   logic [31:0] ma_in;
   logic [31:0] mb_in;
   logic        early;

   always_comb begin
      sa_in = 1'b0;
      sb_in = 1'b0;
      unique case (funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            sa_in = rs1[31];
            sb_in = rs2[31];
         end
         3'b010:  sa_in = rs1[31];
         default: ;
      endcase
      dz_in = funct3[2] && (rs2 == 32'd0);
      // divide by zero passes raw values through the fixup stage
      if (dz_in) begin
         sa_in = 1'b0;
         sb_in = 1'b0;
      end
      ma_in = sa_in ? (~rs1 + 32'd1) : rs1;
      mb_in = sb_in ? (~rs2 + 32'd1) : rs2;
`ifdef MULDIV_EARLY_OUT_EN
      early = dz_in
            || (!funct3[2] && (ma_in == 32'd0 || mb_in == 32'd0))
            || (funct3[2] && mb_in == 32'd1);
`else
      early = 1'b0;
`endif
   end

   logic [63:0] acc_n;
   logic [63:0] mcand_n;
   logic [31:0] mplier_n;
   logic [31:0] rem_n;
   logic [31:0] quo_n;
   logic [32:0] t;
   logic [31:0] diff;

   // Both engines step every cycle; only the one matching is_div is used.
   always_comb begin
      acc_n    = acc;
      mcand_n  = mcand;
      mplier_n = mplier;
      rem_n    = rem;
      quo_n    = quo;
      t        = 33'd0;
      diff     = 32'd0;
      for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
         if (mplier_n[0]) acc_n = acc_n + mcand_n;
         mcand_n  = mcand_n << 1;
         mplier_n = mplier_n >> 1;
         // partial remainder stays below the divisor, so 32 bits hold it
         t    = {rem_n, quo_n[31]};
         diff = t[31:0] - dvsr;
         if (t >= {1'b0, dvsr}) begin
            rem_n = diff;
            quo_n = {quo_n[30:0], 1'b1};
         end else begin
            rem_n = t[31:0];
            quo_n = {quo_n[30:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         is_div     <= 1'b0;
         op_mul     <= 2'd0;
         op_div     <= 2'd0;
         p          <= 64'd0;
         q          <= 32'd0;
         r          <= 32'd0;
         sign_a     <= 1'b0;
         sign_b     <= 1'b0;
         divisor_2c <= 32'd0;
         cnt        <= 6'd0;
         acc        <= 64'd0;
         mcand      <= 64'd0;
         mplier     <= 32'd0;
         rem        <= 32'd0;
         quo        <= 32'd0;
         dvsr       <= 32'd0;
         raw_a      <= 32'd0;
         div0       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready   <= 1'b0;
                  is_div     <= funct3[2];
                  op_mul     <= funct3[2] ? 2'd0 : funct3[1:0];
                  op_div     <= funct3[2] ? funct3[1:0] : 2'd0;
                  divisor_2c <= ~rs2 + 32'd1;
                  sign_a     <= sa_in;
                  sign_b     <= sb_in;
                  cnt        <= 6'd0;
                  acc        <= 64'd0;
                  mcand      <= {32'd0, ma_in};
                  mplier     <= mb_in;
                  rem        <= 32'd0;
                  quo        <= ma_in;
                  dvsr       <= mb_in;
                  raw_a      <= rs1;
                  div0       <= dz_in;
                  if (early) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     if (funct3[2]) begin
                        q <= dz_in ? 32'hFFFF_FFFF : ma_in;
                        r <= dz_in ? rs1 : 32'd0;
                     end else begin
                        p <= 64'd0;
                     end
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (kill) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end else begin
                  acc    <= acc_n;
                  mcand  <= mcand_n;
                  mplier <= mplier_n;
                  rem    <= rem_n;
                  quo    <= quo_n;
                  cnt    <= cnt + 6'd1;
                  if (cnt == LAST) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     if (is_div) begin
                        q <= div0 ? 32'hFFFF_FFFF : quo_n;
                        r <= div0 ? raw_a : rem_n;
                     end else begin
                        p <= acc_n;
                     end
                  end
               end
            end
            DONE: begin
               if (kill || out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_iter_core.sv
// tb_muldiv_iter_core: scoreboard bench for muldiv_iter_core.
// Random and directed RV32M requests against an arithmetic reference model.
module tb_muldiv_iter_core;

   localparam int S = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] rs1 = 32'd0;
   logic [31:0] rs2 = 32'd0;
   logic        kill = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        is_div;
   logic [1:0]  op_mul;
   logic [1:0]  op_div;
   logic [63:0] p;
   logic [31:0] q;
   logic [31:0] r;
   logic        sign_a;
   logic        sign_b;
   logic [31:0] divisor_2c;

   muldiv_iter_core #(.STEPS_PER_CYCLE(S)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .funct3(funct3), .rs1(rs1), .rs2(rs2), .kill(kill),
      .out_valid(out_valid), .out_ready(out_ready),
      .is_div(is_div), .op_mul(op_mul), .op_div(op_div),
      .p(p), .q(q), .r(r),
      .sign_a(sign_a), .sign_b(sign_b), .divisor_2c(divisor_2c)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        is_div;
      logic [1:0]  om;
      logic [1:0]  od;
      logic [63:0] p;
      logic [31:0] q;
      logic [31:0] r;
      logic [31:0] d2c;
      logic        sa;
      logic        sb;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t sbq[$];
   int errors = 0;
   int checks = 0;
   int rdy_mode = 1;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] f,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t e;
      logic [31:0] ma;
      logic [31:0] mb;
      logic dz;
      logic early;
      e.is_div = f[2];
      e.om  = f[2] ? 2'd0 : f[1:0];
      e.od  = f[2] ? f[1:0] : 2'd0;
      e.d2c = -b;
      e.sa  = a[31] && (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
      e.sb  = b[31] && (f inside {3'd0, 3'd1, 3'd4, 3'd6});
      ma = e.sa ? -a : a;
      mb = e.sb ? -b : b;
      dz = f[2] && (b == 32'd0);
      e.p = 64'(ma) * 64'(mb);
      e.q = 32'd0;
      e.r = 32'd0;
      if (dz) begin
         e.sa = 1'b0;
         e.sb = 1'b0;
         e.q  = 32'hFFFF_FFFF;
         e.r  = a;
      end else if (f[2]) begin
         e.q = ma / mb;
         e.r = ma % mb;
      end
`ifdef MULDIV_EARLY_OUT_EN
      early = dz || (!f[2] && (ma == 0 || mb == 0)) || (f[2] && mb == 1);
`else
      early = 1'b0;
`endif
      e.lat = early ? 1 : 32 / S + 1;
      e.acc_cyc = 0;
      return e;
   endfunction

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) out_ready = 1'b1;
      else if (rdy_mode == 2) out_ready = 1'b0;
      else out_ready = ($urandom_range(0, 3) != 0);
   end

   logic pv = 1'b0;
   logic pend_ir = 1'b0;
   int   rise = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0;
         pend_ir = 1'b0;
      end else begin
         if (pend_ir) begin
            chk("in_ready_after_hs", 64'(in_ready), 64'd1);
            pend_ir = 1'b0;
         end
         if (out_valid) begin
            if (!pv) rise = cyc;
            chk("in_ready_in_done", 64'(in_ready), 64'd0);
            if (sbq.size() == 0) begin
               chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
               chk("is_div", 64'(is_div), 64'(sbq[0].is_div));
               chk("op_mul", 64'(op_mul), 64'(sbq[0].om));
               chk("op_div", 64'(op_div), 64'(sbq[0].od));
               chk("sign_a", 64'(sign_a), 64'(sbq[0].sa));
               chk("sign_b", 64'(sign_b), 64'(sbq[0].sb));
               chk("divisor_2c", 64'(divisor_2c), 64'(sbq[0].d2c));
               if (sbq[0].is_div) begin
                  chk("q", 64'(q), 64'(sbq[0].q));
                  chk("r", 64'(r), 64'(sbq[0].r));
               end else begin
                  chk("p", p, sbq[0].p);
               end
               if (out_ready) begin
                  chk("latency", 64'(rise - sbq[0].acc_cyc),
                      64'(sbq[0].lat));
                  void'(sbq.pop_front());
                  pend_ir = 1'b1;
               end
            end
         end
         pv = out_valid;
      end
   end

   task automatic issue(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit track);
      exp_t e;
      bit ok;
      ok = 1'b0;
      funct3 = f;
      rs1 = a;
      rs2 = b;
      in_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk("accept_timeout", 64'd1, 64'd0);
      end else if (track) begin
         e = model(f, a, b);
         e.acc_cyc = cyc;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (sbq.size() == 0) break;
      end
      chk("drain", 64'(sbq.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit seen;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctl", 64'({out_valid, in_ready, is_div, op_mul, op_div,
                            sign_a, sign_b}), 64'd0);
      chk("reset_p", p, 64'd0);
      chk("reset_qr", {q, r}, 64'd0);
      chk("reset_d2c", 64'(divisor_2c), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(3'b001, 32'hFFFF_FFFE, 32'd3, 1'b1);
      issue(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1);
      issue(3'b110, 32'h8000_0005, 32'd0, 1'b1);
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      drain();

      rdy_mode = 2;
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("stall_reach_done", 64'(seen), 64'd1);
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_p", p, 64'hFFFF_FFFE_0000_0001);
      end
      rdy_mode = 1;
      drain();

      issue(3'b000, 32'd12345, 32'd6789, 1'b0);
      repeat (9) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      @(negedge clk);
      chk("kill_in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("kill_no_valid", 64'(seen), 64'd0);
      chk("kill_p_kept", p, 64'hFFFF_FFFE_0000_0001);
      @(posedge clk);
      #1 kill = 1'b1;
      issue(3'b010, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
      kill = 1'b0;
      drain();

      rdy_mode = 0;
      repeat (250) begin
         issue(3'($urandom), pick(), pick(), 1'b1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      drain();

      rdy_mode = 1;
      issue(3'b101, 32'hDEAD_BEEF, 32'd7, 1'b0);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_ctl", 64'({out_valid, in_ready, is_div, op_mul, op_div,
                              sign_a, sign_b}), 64'd0);
      chk("rst_mid_p", p, 64'd0);
      chk("rst_mid_qr", {q, r}, 64'd0);
      chk("rst_mid_d2c", 64'(divisor_2c), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("rst_no_valid", 64'(seen), 64'd0);
      @(posedge clk);
      #1;
      issue(3'b000, 32'd7, 32'hFFFF_FFFA, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
